// File: rtl/hello_debounce.sv
// Input conditioner for hello: synchronizes a raw asynchronous level and debounces it with a
// counter-qualified FSM. Define HELLO_DEBOUNCE_EDGE_EN to add the a_rise/a_fall pulse outputs.
module hello_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    output logic a_clean,
    output logic busy
`ifdef HELLO_DEBOUNCE_EDGE_EN
    ,
    output logic a_rise,
    output logic a_fall
`endif
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   clean_nxt_s;
    logic                   busy_nxt_s;
    logic                   a_clean_r;
    logic                   busy_r;

    // Metastability synchronizer chain; only its last stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], a_raw};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    // FSM state and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= STABLE_LO;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: a candidate level must hold DEBOUNCE_CYCLES samples after entry.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            STABLE_LO: begin
                if (s_s) begin
                    state_nxt_s = WAIT_HI;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = STABLE_LO;
                end
            end
            WAIT_HI: begin
                if (!s_s) begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = STABLE_HI;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!s_s) begin
                    state_nxt_s = WAIT_LO;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = STABLE_HI;
                end
            end
            WAIT_LO: begin
                if (s_s) begin
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = STABLE_LO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = STABLE_LO;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        clean_nxt_s = (state_nxt_s == STABLE_HI) || (state_nxt_s == WAIT_LO);
        busy_nxt_s  = (state_nxt_s == WAIT_HI) || (state_nxt_s == WAIT_LO);
    end

    // Registered level outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_clean_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            a_clean_r <= clean_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign a_clean = a_clean_r;
    assign busy    = busy_r;

`ifdef HELLO_DEBOUNCE_EDGE_EN
    logic a_rise_r;
    logic a_fall_r;

    // Edge pulses coincide with the first cycle a_clean shows its new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rise_r <= 1'b0;
            a_fall_r <= 1'b0;
        end else begin
            a_rise_r <= clean_nxt_s & ~a_clean_r;
            a_fall_r <= ~clean_nxt_s & a_clean_r;
        end
    end

    assign a_rise = a_rise_r;
    assign a_fall = a_fall_r;
`endif

endmodule

// File: tb/tb_hello_debounce.sv
// Scoreboard bench for hello_debounce: a posedge reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hello_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 8;

    typedef struct packed {
        logic clean;
        logic busy;
        logic rise;
        logic fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b0;
    logic a_clean;
    logic busy;
    logic a_rise;
    logic a_fall;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference model state: the level the FSM sees is a_raw delayed by SYNC edges, and the
    // clean level flips once the last DEB+1 seen samples all disagree with it.
    logic raw_q[$];
    logic win[$];
    logic m_clean = 1'b0;

    hello_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a_raw  (a_raw),
        .a_clean(a_clean),
        .busy   (busy)
`ifdef HELLO_DEBOUNCE_EDGE_EN
        ,
        .a_rise (a_rise),
        .a_fall (a_fall)
`endif
    );

`ifndef HELLO_DEBOUNCE_EDGE_EN
    assign a_rise = 1'b0;
    assign a_fall = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one expected output record per rising edge.
    always @(posedge clk) begin
        exp_t e;
        logic s;
        logic prev;
        logic flip;
        e = '0;
        if (rst) begin
            raw_q.delete();
            for (int i = 0; i < SYNC; i++) raw_q.push_back(1'b0);
            win.delete();
            m_clean = 1'b0;
        end else begin
            s = raw_q.pop_front();
            raw_q.push_back(a_raw);
            win.push_back(s);
            if (win.size() > DEB + 1) void'(win.pop_front());
            prev = m_clean;
            flip = (win.size() == DEB + 1);
            foreach (win[i]) if (win[i] == m_clean) flip = 1'b0;
            if (flip) m_clean = ~m_clean;
            e.clean = m_clean;
            e.busy  = (s != m_clean);
            e.rise  = m_clean & ~prev;
            e.fall  = ~m_clean & prev;
        end
        exp_q.push_back(e);
    end

    // Monitor: compares DUT outputs mid-cycle against the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("a_clean", a_clean, e.clean);
            check("busy", busy, e.busy);
`ifdef HELLO_DEBOUNCE_EDGE_EN
            check("a_rise", a_rise, e.rise);
            check("a_fall", a_fall, e.fall);
`endif
            check("cnt_bound", (int'(dut.cnt_r) <= DEB - 1), 1'b1);
        end
    end

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_raw = v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_raw = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_clean", a_clean, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        hold(1'b1, 20);

        // Release, press, release again.
        hold(1'b0, 20);
        hold(1'b1, 20);
        hold(1'b0, 20);

        // Bounce then settle high.
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 20);
        hold(1'b0, 20);

        // Glitch shorter than the qualification window.
        hold(1'b1, 3);
        hold(1'b0, 15);

        // Reset asserted two cycles into WAIT_HI.
        @(negedge clk);
        a_raw = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_clean", a_clean, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cnt", (dut.cnt_r == 8'd0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 15);

        // Randomized runs of random lengths.
        for (int k = 0; k < 80; k++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        hold(1'b0, 12);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
